ctr_pwm_gen: RTL and testbench

Downstream consumer of the up/down binary counter. Samples the counter value and direction every clock and produces a registered PWM output by comparing the count against a double-buffered duty value. Also produces a wrap pulse, a direction-change pulse and a saturating wrap counter for the control logic that sequences the counter's `mode`.

---
 rtl/ctr_pwm_gen_if.sv | 29 ++
 rtl/ctr_pwm_gen.sv | 99 +++++++++
 tb/tb_ctr_pwm_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctr_pwm_gen_if.sv
// Signal bundle between the up/down counter's monitor side and ctr_pwm_gen.
// The master drives the counter sample, the enable and the duty write; the slave returns the registered results.
interface ctr_pwm_gen_if #(
    parameter int WIDTH  = 4,
    parameter int WCNT_W = 8
);
    logic [WIDTH-1:0]  q_in;
    logic              mode;
    logic              enable;
    logic [WIDTH-1:0]  duty_in;
    logic              duty_wr;
    logic              pwm_out;
    logic              wrap;
    logic              dir_chg;
    logic [WIDTH-1:0]  duty_active;
    logic [WCNT_W-1:0] wrap_cnt;

    // duty_wr is a bare strobe: sampled on every edge and always accepted.
    // There is no ready, so the writer never stalls and a held strobe keeps rewriting.
    modport master (
        output q_in, mode, enable, duty_in, duty_wr,
        input  pwm_out, wrap, dir_chg, duty_active, wrap_cnt
    );

    modport slave (
        input  q_in, mode, enable, duty_in, duty_wr,
        output pwm_out, wrap, dir_chg, duty_active, wrap_cnt
    );
endinterface

// File: rtl/ctr_pwm_gen.sv
// PWM generator that follows an external up/down counter.
// It also flags counter wraps and direction changes, and counts wraps with saturation.
module ctr_pwm_gen #(
    parameter int WIDTH  = 4,
    parameter int WCNT_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    ctr_pwm_gen_if.slave bus
);
    localparam logic [WIDTH-1:0]  ONES     = '1;
    localparam logic [WCNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0]  q_prev_q, q_prev_d;
    logic              mode_prev_q, mode_prev_d;
    logic              seen_q, seen_d;
    logic [WIDTH-1:0]  duty_shadow_q, duty_shadow_d;
    logic              pend_q, pend_d;
    logic [WIDTH-1:0]  duty_active_q, duty_active_d;
    logic              pwm_q, pwm_d;
    logic              wrap_q, wrap_d;
    logic              dir_chg_q, dir_chg_d;
    logic [WCNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic              same_dir;
    logic              up_wrap;
    logic              dn_wrap;

    always_comb begin
        q_prev_d      = bus.q_in;
        mode_prev_d   = bus.mode;
        seen_d        = 1'b1;
        duty_shadow_d = duty_shadow_q;
        pend_d        = pend_q;
        duty_active_d = duty_active_q;
        wrap_cnt_d    = wrap_cnt_q;

        // The wrap pattern must match the current direction.
        // A sample that flips direction is reported only as a direction change.
        same_dir  = (bus.mode == mode_prev_q);
        up_wrap   = bus.mode  && (q_prev_q == ONES) && (bus.q_in == '0);
        dn_wrap   = !bus.mode && (q_prev_q == '0)   && (bus.q_in == ONES);
        wrap_d    = seen_q && same_dir && (up_wrap || dn_wrap);
        dir_chg_d = seen_q && !same_dir;

        if (bus.duty_wr) begin
            duty_shadow_d = bus.duty_in;
            pend_d        = 1'b1;
        end

        if (wrap_d) begin
            if (bus.duty_wr) begin
                duty_active_d = bus.duty_in;
                pend_d        = 1'b0;
            end else if (pend_q) begin
                duty_active_d = duty_shadow_q;
                pend_d        = 1'b0;
            end
            if (wrap_cnt_q != CNT_MAX) begin
                wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
        end

        // Compare against the duty taking effect at this edge, so a new period opens with the new duty.
        pwm_d = bus.enable && (bus.q_in < duty_active_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_prev_q      <= '0;
            mode_prev_q   <= 1'b0;
            seen_q        <= 1'b0;
            duty_shadow_q <= '0;
            pend_q        <= 1'b0;
            duty_active_q <= '0;
            pwm_q         <= 1'b0;
            wrap_q        <= 1'b0;
            dir_chg_q     <= 1'b0;
            wrap_cnt_q    <= '0;
        end else begin
            q_prev_q      <= q_prev_d;
            mode_prev_q   <= mode_prev_d;
            seen_q        <= seen_d;
            duty_shadow_q <= duty_shadow_d;
            pend_q        <= pend_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
            wrap_q        <= wrap_d;
            dir_chg_q     <= dir_chg_d;
            wrap_cnt_q    <= wrap_cnt_d;
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.wrap        = wrap_q;
    assign bus.dir_chg     = dir_chg_q;
    assign bus.duty_active = duty_active_q;
    assign bus.wrap_cnt    = wrap_cnt_q;
endmodule

// File: tb/tb_ctr_pwm_gen.sv
// Directed bench for ctr_pwm_gen: a vector table plus hand-written period, saturation and reset sequences.
// A second instance with a 2-bit wrap counter sees the same inputs to exercise saturation.
module tb_ctr_pwm_gen;
    logic clk;
    logic rst_n;

    ctr_pwm_gen_if #(.WIDTH(4), .WCNT_W(8)) bus ();
    ctr_pwm_gen_if #(.WIDTH(4), .WCNT_W(2)) bus2 ();

    ctr_pwm_gen #(.WIDTH(4), .WCNT_W(8)) dut  (.clk(clk), .reset(rst_n), .bus(bus.slave));
    ctr_pwm_gen #(.WIDTH(4), .WCNT_W(2)) dut2 (.clk(clk), .reset(rst_n), .bus(bus2.slave));

    assign bus2.q_in    = bus.q_in;
    assign bus2.mode    = bus.mode;
    assign bus2.enable  = bus.enable;
    assign bus2.duty_in = bus.duty_in;
    assign bus2.duty_wr = bus.duty_wr;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] q;
        logic       m;
        logic       en;
        logic [3:0] din;
        logic       wr;
        logic       pwm;
        logic       wrap;
        logic       dchg;
        logic [3:0] act;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [3:0] q, input logic m, input logic en,
                         input logic [3:0] din, input logic wr);
        bus.q_in    = q;
        bus.mode    = m;
        bus.enable  = en;
        bus.duty_in = din;
        bus.duty_wr = wr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic pwm, input logic wrap, input logic dchg,
                             input logic [3:0] act, input logic [7:0] cnt, input logic [1:0] cnt2);
        check({tag, " pwm"},     int'(bus.pwm_out),     int'(pwm));
        check({tag, " wrap"},    int'(bus.wrap),        int'(wrap));
        check({tag, " dir_chg"}, int'(bus.dir_chg),     int'(dchg));
        check({tag, " duty"},    int'(bus.duty_active), int'(act));
        check({tag, " cnt"},     int'(bus.wrap_cnt),    int'(cnt));
        check({tag, " cnt2"},    int'(bus2.wrap_cnt),   int'(cnt2));
    endtask

    // One full up period q=0..15 with an optional duty write on the wrap cycle.
    task automatic run_period(input logic en, input logic [3:0] din, input logic wr,
                              output int highs, output int wraps);
        highs = 0;
        wraps = 0;
        for (int q = 0; q < 16; q++) begin
            drive(4'(q), 1'b1, en, din, (q == 0) ? wr : 1'b0);
            step();
            highs += int'(bus.pwm_out);
            wraps += int'(bus.wrap);
        end
    endtask

    initial begin
        int highs;
        int wraps;
        logic [7:0] e;

        //            q   m  en din wr  pwm wrp dch act cnt cnt2
        tbl.push_back('{4'd14, 1, 1, 4'd5,  1, 0, 0, 0, 4'd0,  8'd0, 2'd0});
        tbl.push_back('{4'd15, 1, 1, 4'd0,  0, 0, 0, 0, 4'd0,  8'd0, 2'd0});
        tbl.push_back('{4'd0,  1, 1, 4'd0,  0, 1, 1, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd1,  1, 1, 4'd0,  0, 1, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd2,  1, 1, 4'd0,  0, 1, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd3,  1, 1, 4'd0,  0, 1, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd4,  1, 1, 4'd0,  0, 1, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd5,  1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd6,  1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd7,  1, 1, 4'd12, 1, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd8,  1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd9,  1, 1, 4'd3,  1, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd10, 1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd11, 1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd12, 1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd13, 1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd14, 1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd15, 1, 1, 4'd0,  0, 0, 0, 0, 4'd5,  8'd1, 2'd1});
        tbl.push_back('{4'd0,  1, 1, 4'd0,  0, 1, 1, 0, 4'd3,  8'd2, 2'd2});
        tbl.push_back('{4'd1,  1, 1, 4'd0,  0, 1, 0, 0, 4'd3,  8'd2, 2'd2});
        tbl.push_back('{4'd2,  1, 1, 4'd0,  0, 1, 0, 0, 4'd3,  8'd2, 2'd2});
        tbl.push_back('{4'd3,  1, 1, 4'd0,  0, 0, 0, 0, 4'd3,  8'd2, 2'd2});
        tbl.push_back('{4'd15, 1, 1, 4'd0,  0, 0, 0, 0, 4'd3,  8'd2, 2'd2});
        tbl.push_back('{4'd0,  1, 1, 4'd10, 1, 1, 1, 0, 4'd10, 8'd3, 2'd3});
        tbl.push_back('{4'd9,  1, 1, 4'd0,  0, 1, 0, 0, 4'd10, 8'd3, 2'd3});
        tbl.push_back('{4'd10, 1, 1, 4'd0,  0, 0, 0, 0, 4'd10, 8'd3, 2'd3});
        tbl.push_back('{4'd11, 0, 1, 4'd0,  0, 0, 0, 1, 4'd10, 8'd3, 2'd3});
        tbl.push_back('{4'd10, 0, 1, 4'd0,  0, 0, 0, 0, 4'd10, 8'd3, 2'd3});
        tbl.push_back('{4'd9,  0, 1, 4'd0,  0, 1, 0, 0, 4'd10, 8'd3, 2'd3});
        tbl.push_back('{4'd0,  0, 1, 4'd0,  0, 1, 0, 0, 4'd10, 8'd3, 2'd3});
        tbl.push_back('{4'd15, 0, 1, 4'd0,  0, 0, 1, 0, 4'd10, 8'd4, 2'd3});
        tbl.push_back('{4'd14, 0, 1, 4'd0,  0, 0, 0, 0, 4'd10, 8'd4, 2'd3});
        tbl.push_back('{4'd15, 0, 1, 4'd0,  0, 0, 0, 0, 4'd10, 8'd4, 2'd3});
        tbl.push_back('{4'd0,  1, 1, 4'd0,  0, 1, 0, 1, 4'd10, 8'd4, 2'd3});
        tbl.push_back('{4'd1,  1, 1, 4'd0,  0, 1, 0, 0, 4'd10, 8'd4, 2'd3});

        rst_n = 1'b0;
        drive(4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        step();
        step();
        check_all("reset", 0, 0, 0, 4'd0, 8'd0, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].q, tbl[i].m, tbl[i].en, tbl[i].din, tbl[i].wr);
            step();
            check_all($sformatf("v%0d", i), tbl[i].pwm, tbl[i].wrap, tbl[i].dchg,
                      tbl[i].act, tbl[i].cnt, tbl[i].cnt2);
        end

        // Finish the period so the next sample is the 15->0 wrap.
        wraps = 0;
        for (int q = 2; q < 16; q++) begin
            drive(4'(q), 1'b1, 1'b1, 4'd0, 1'b0);
            step();
            wraps += int'(bus.wrap);
        end
        check("ramp no wrap", wraps, 0);

        // Expected high cycles per period: duty 5 (written on wrap), 5 again, 0, 15, disabled, 15.
        exp_q.push_back(8'd5);
        exp_q.push_back(8'd5);
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd15);
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd15);
        run_period(1'b1, 4'd5,  1'b1, highs, wraps);
        e = exp_q.pop_front();
        check("p1 duty5 highs", highs, int'(e));
        check("p1 wraps", wraps, 1);
        check("p1 duty", int'(bus.duty_active), 5);
        run_period(1'b1, 4'd0,  1'b0, highs, wraps);
        e = exp_q.pop_front();
        check("p2 duty5 highs", highs, int'(e));
        run_period(1'b1, 4'd0,  1'b1, highs, wraps);
        e = exp_q.pop_front();
        check("p3 duty0 highs", highs, int'(e));
        run_period(1'b1, 4'd15, 1'b1, highs, wraps);
        e = exp_q.pop_front();
        check("p4 duty15 highs", highs, int'(e));
        run_period(1'b0, 4'd0,  1'b0, highs, wraps);
        e = exp_q.pop_front();
        check("p5 disabled highs", highs, int'(e));
        check("p5 disabled wraps", wraps, 1);
        run_period(1'b1, 4'd0,  1'b0, highs, wraps);
        e = exp_q.pop_front();
        check("p6 reenabled highs", highs, int'(e));
        check("wrap_cnt after 10", int'(bus.wrap_cnt), 10);
        check("wrap_cnt2 saturated", int'(bus2.wrap_cnt), 3);

        // Mid-operation reset with duty 9 active and 7 pending.
        drive(4'd0, 1'b1, 1'b1, 4'd9, 1'b1);
        step();
        check("pre-reset duty", int'(bus.duty_active), 9);
        for (int q = 1; q <= 6; q++) begin
            drive(4'(q), 1'b1, 1'b1, 4'd7, (q == 3) ? 1'b1 : 1'b0);
            step();
        end
        check("pre-reset pwm q6", int'(bus.pwm_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 0, 0, 0, 4'd0, 8'd0, 2'd0);
        drive(4'd15, 1'b1, 1'b1, 4'd0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        drive(4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        step();
        check_all("first edge", 0, 0, 0, 4'd0, 8'd0, 2'd0);
        wraps = 0;
        for (int q = 1; q < 16; q++) begin
            drive(4'(q), 1'b1, 1'b1, 4'd0, 1'b0);
            step();
            wraps += int'(bus.wrap) + int'(bus.dir_chg);
        end
        check("post-reset quiet", wraps, 0);
        drive(4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        step();
        check_all("post-reset wrap", 0, 1, 0, 4'd0, 8'd1, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
